hamming74_link_ctrl: RTL and testbench
======================================

Name: hamming74_link_ctrl

Overview:
- Sequencing controller for the Hamming(7,4) encode / error-inject / correct datapath.
- Accepts nibbles and configuration writes over a strobed 8-bit input port.
- Per frame, runs the same codeword, injection and correction mapping as the combinational core in a fixed sequence.
- Streams three output beats per frame (received word, corrected word, status) and keeps a saturating error count.

Parameters:
- HOLD, 2, clock cycles each output beat is held (>=1).

Ports:
- io_in[0]  input  1  clk; all flops on rising edge.
- io_in[1]  input  1  reset; asynchronous, active-high.
- io_in[2]  input  1  strb; command strobe, rising-edge detected.
- io_in[6:3]  input  4  payload: nibble d3..d0 (data command) or {corr_en, pos[2:0]} (config command).
- io_in[7]  input  1  cmd; 0 = data, 1 = config.
- io_out[6:0]  output  7  beat value.
- io_out[7]  output  1  vld; high during output beats.

Behaviour:
- Codeword: c0..c3 = d0..d3; c4 = d0^d1^d3; c5 = d0^d2^d3; c6 = d1^d2^d3.
- Injection, pos -> flipped bit: 0 none, 1->c3, 2->c1, 3->c5, 4->c0, 5->c4, 6->c2, 7->c6.
- Syndrome: s0 = c0^c1^c3^c4; s1 = c0^c2^c3^c5; s2 = c1^c2^c3^c6; syn = {s2,s1,s0}.
- Correction, syn -> flipped bit: 3->c0, 5->c1, 6->c2, 7->c3, 1->c4, 2->c5, 4->c6, 0 none.
- Edge detect: strb_q registered each cycle; event = strb & ~strb_q. A held strobe yields exactly one event.
- Reset values:
  - state IDLE, io_out = 0x00, strb_q = 0.
  - pos = 0, corr_en = 1, err_cnt (4 b) = 0, beat counter = 0.
- IDLE:
  - Event with cmd=1: load pos = io_in[5:3], corr_en = io_in[6]; clear err_cnt. Stay IDLE.
  - Event with cmd=0: latch nibble; go to ENC.
  - io_out[7] = 0; io_out[6:0] holds the last beat.
- ENC (1 cycle): rx <= encode(nibble) ^ inject(pos). Go to CHK.
- CHK (1 cycle):
  - syn <= syndrome(rx).
  - fix <= corr_en ? rx ^ correct(syn) : rx.
  - If syn != 0, err_cnt++, saturating at 15.
  - Go to B_RX.
- B_RX (HOLD cycles): io_out = {1, rx}.
- B_FIX (HOLD cycles): io_out = {1, fix}.
- B_STAT (HOLD cycles): io_out = {1, syn[2:0], err_cnt[3:0]}. Shows the count after this frame's update.
- After B_STAT: return to IDLE; io_out[7] cleared.
- io_out is fully registered and loaded on the edge that enters each beat.
- Latency: event sampled at edge N -> ENC. io_out = {1, rx} appears at edge N+3. io_out[7] drops at edge N+3+3*HOLD.
- Events (data or config) in any non-IDLE state are discarded; no queuing.
  - strb_q still tracks, so a strobe held across the return to IDLE does not retrigger.
- A config write affects only frames whose data event comes after it.
- Simultaneous counter saturation and increment: the count stays at 15.
- Reset asserted in any state: immediate return to reset values; the frame in flight is dropped.
  - After release, the first rising strb edge is required; a strb already high at release produces no event.

Test Plan:
- Reset; data 0xB (pos=0) -> B_RX io_out=0x9B, B_FIX 0x9B, B_STAT 0x80; each beat lasts 2 cycles; first beat 3 cycles after the event.
- Config {corr_en=1, pos=6}, then data 0xB -> rx 0x1F (io_out 0x9F), fix 0x1B (io_out 0x9B), status 0xE1 (syn=6, cnt=1).
- Config {corr_en=0, pos=6}, then data 0xB -> fix 0x1F uncorrected; status 0xE1; the config write cleared cnt first.
- Sweep pos 1..7 for all 16 nibbles with corr_en=1 -> fix always equals the clean codeword; syn follows the mapping; cnt saturates at 15 (status low nibble 0xF).
- Strobe held high for 20 cycles, plus a second pulse during B_FIX -> exactly one frame emitted; the second pulse is ignored; cnt is unchanged by it.
- Reset pulse during B_RX -> io_out=0x00 asynchronously, pos=0, corr_en=1, cnt=0; the next clean data event works normally.

Source files
------------

// File: rtl/hamming74_link_ctrl.sv
// Hamming(7,4) link controller: strobed nibble/config input, encode -> inject -> check/correct,
// then three held output beats (received, corrected, status) with a saturating error count.
module hamming74_link_ctrl #(
  parameter int HOLD = 2
) (
  input  logic [7:0] io_in,
  output logic [7:0] io_out
);

  localparam int BW = (HOLD > 1) ? $clog2(HOLD) : 1;

  typedef enum logic [2:0] {IDLE, ENC, CHK, B_RX, B_FIX, B_STAT} state_t;

  logic       clk, rst, strb, cmd;
  logic [3:0] payload;

  assign clk     = io_in[0];
  assign rst     = io_in[1];
  assign strb    = io_in[2];
  assign payload = io_in[6:3];
  assign cmd     = io_in[7];

  state_t          state_q, state_d;
  logic            strb_q, strb_d;
  logic            arm_q, arm_d;
  logic [3:0]      nib_q, nib_d;
  logic [2:0]      pos_q, pos_d;
  logic            corr_en_q, corr_en_d;
  logic [3:0]      err_cnt_q, err_cnt_d;
  logic [BW-1:0]   beat_q, beat_d;
  logic [6:0]      rx_q, rx_d;
  logic [6:0]      fix_q, fix_d;
  logic [2:0]      syn_q, syn_d;
  logic [7:0]      out_q, out_d;

  logic            evt, last_beat;
  logic [6:0]      cw, inj, cor;
  logic [2:0]      syn_c;

  // arm_q blocks a strobe that was already high when reset released
  assign evt       = strb & ~strb_q & arm_q;
  assign last_beat = (beat_q == BW'(HOLD - 1));

  always_comb begin
    cw = {nib_q[1] ^ nib_q[2] ^ nib_q[3],
          nib_q[0] ^ nib_q[2] ^ nib_q[3],
          nib_q[0] ^ nib_q[1] ^ nib_q[3],
          nib_q};

    inj = '0;
    case (pos_q)
      3'd1:    inj[3] = 1'b1;
      3'd2:    inj[1] = 1'b1;
      3'd3:    inj[5] = 1'b1;
      3'd4:    inj[0] = 1'b1;
      3'd5:    inj[4] = 1'b1;
      3'd6:    inj[2] = 1'b1;
      3'd7:    inj[6] = 1'b1;
      default: inj    = '0;
    endcase

    syn_c = {rx_q[1] ^ rx_q[2] ^ rx_q[3] ^ rx_q[6],
             rx_q[0] ^ rx_q[2] ^ rx_q[3] ^ rx_q[5],
             rx_q[0] ^ rx_q[1] ^ rx_q[3] ^ rx_q[4]};

    cor = '0;
    case (syn_c)
      3'd3:    cor[0] = 1'b1;
      3'd5:    cor[1] = 1'b1;
      3'd6:    cor[2] = 1'b1;
      3'd7:    cor[3] = 1'b1;
      3'd1:    cor[4] = 1'b1;
      3'd2:    cor[5] = 1'b1;
      3'd4:    cor[6] = 1'b1;
      default: cor    = '0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    strb_d    = strb;
    arm_d     = arm_q | ~strb;
    nib_d     = nib_q;
    pos_d     = pos_q;
    corr_en_d = corr_en_q;
    err_cnt_d = err_cnt_q;
    beat_d    = beat_q;
    rx_d      = rx_q;
    fix_d     = fix_q;
    syn_d     = syn_q;
    out_d     = out_q;

    case (state_q)
      IDLE: begin
        out_d = {1'b0, out_q[6:0]};
        if (evt) begin
          if (cmd) begin
            pos_d     = payload[2:0];
            corr_en_d = payload[3];
            err_cnt_d = '0;
          end else begin
            nib_d   = payload;
            state_d = ENC;
          end
        end
      end
      ENC: begin
        rx_d    = cw ^ inj;
        state_d = CHK;
      end
      CHK: begin
        syn_d   = syn_c;
        fix_d   = corr_en_q ? (rx_q ^ cor) : rx_q;
        if ((syn_c != 3'd0) && (err_cnt_q != 4'hF)) err_cnt_d = err_cnt_q + 4'd1;
        beat_d  = '0;
        state_d = B_RX;
      end
      // io_out trails the beat state by one edge, so each beat lands on io_out as it begins
      B_RX: begin
        out_d   = {1'b1, rx_q};
        beat_d  = last_beat ? '0 : beat_q + BW'(1);
        if (last_beat) state_d = B_FIX;
      end
      B_FIX: begin
        out_d   = {1'b1, fix_q};
        beat_d  = last_beat ? '0 : beat_q + BW'(1);
        if (last_beat) state_d = B_STAT;
      end
      B_STAT: begin
        out_d   = {1'b1, syn_q, err_cnt_q};
        beat_d  = last_beat ? '0 : beat_q + BW'(1);
        if (last_beat) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      strb_q    <= 1'b0;
      arm_q     <= 1'b0;
      nib_q     <= '0;
      pos_q     <= '0;
      corr_en_q <= 1'b1;
      err_cnt_q <= '0;
      beat_q    <= '0;
      rx_q      <= '0;
      fix_q     <= '0;
      syn_q     <= '0;
      out_q     <= '0;
    end else begin
      state_q   <= state_d;
      strb_q    <= strb_d;
      arm_q     <= arm_d;
      nib_q     <= nib_d;
      pos_q     <= pos_d;
      corr_en_q <= corr_en_d;
      err_cnt_q <= err_cnt_d;
      beat_q    <= beat_d;
      rx_q      <= rx_d;
      fix_q     <= fix_d;
      syn_q     <= syn_d;
      out_q     <= out_d;
    end
  end

  assign io_out = out_q;

endmodule

// File: tb/tb_hamming74_link_ctrl.sv
// Bench for hamming74_link_ctrl: timeline model checked every cycle plus directed literal checks.
module tb_hamming74_link_ctrl;

  localparam int H = 2;

  logic       clk = 1'b0, rst = 1'b0, strb = 1'b0, cmd = 1'b0;
  logic [3:0] payload = 4'h0;
  wire  [7:0] io_in = {cmd, payload, strb, rst, clk};
  logic [7:0] io_out;

  hamming74_link_ctrl #(.HOLD(H)) dut (.io_in(io_in), .io_out(io_out));

  always #5 clk = ~clk;

  int n_chk = 0, n_pass = 0;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%02h, want 0x%02h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [6:0] encode(input logic [3:0] d);
    return {d[1] ^ d[2] ^ d[3], d[0] ^ d[2] ^ d[3], d[0] ^ d[1] ^ d[3], d};
  endfunction

  function automatic logic [6:0] inj_mask(input logic [2:0] p);
    int bitpos [8] = '{0, 3, 1, 5, 0, 4, 2, 6};
    logic [6:0] m = '0;
    if (p != 3'd0) m[bitpos[p]] = 1'b1;
    return m;
  endfunction

  function automatic logic [2:0] syndrome(input logic [6:0] c);
    return {c[1] ^ c[2] ^ c[3] ^ c[6], c[0] ^ c[2] ^ c[3] ^ c[5], c[0] ^ c[1] ^ c[3] ^ c[4]};
  endfunction

  // Decode by searching for the codeword within distance 1
  function automatic logic [6:0] nearest(input logic [6:0] c);
    for (int d = 0; d < 16; d++)
      if ($countones(encode(4'(d)) ^ c) <= 1) return encode(4'(d));
    return c;
  endfunction

  typedef struct { int at; logic [7:0] v; } ev_t;
  ev_t        sched [$];
  int         cyc = 0, free_at = 0, m_cnt = 0;
  bit         last_strb = 0, armed = 0, m_corr = 1, m_evt;
  logic [2:0] m_pos = '0, m_syn;
  logic [6:0] m_rx, m_fix;
  logic [7:0] exp_val = '0, m_st;

  task automatic sched_push(input int at, input logic [7:0] v);
    ev_t e;
    e.at = at;
    e.v  = v;
    sched.push_back(e);
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      sched.delete();
      exp_val = '0; m_pos = '0; m_corr = 1; m_cnt = 0;
      free_at = 0; armed = 0; last_strb = 0;
    end else begin
      cyc++;
      m_evt = strb && !last_strb && armed;
      if (!strb) armed = 1;
      last_strb = strb;
      if (m_evt && cyc >= free_at) begin
        if (cmd) begin
          m_pos = payload[2:0]; m_corr = payload[3]; m_cnt = 0;
        end else begin
          m_rx  = encode(payload) ^ inj_mask(m_pos);
          m_syn = syndrome(m_rx);
          m_fix = m_corr ? nearest(m_rx) : m_rx;
          if (m_syn != 3'd0 && m_cnt < 15) m_cnt++;
          m_st  = {1'b1, m_syn, 4'(m_cnt)};
          sched_push(cyc + 3,         {1'b1, m_rx});
          sched_push(cyc + 3 + H,     {1'b1, m_fix});
          sched_push(cyc + 3 + 2 * H, m_st);
          sched_push(cyc + 3 + 3 * H, {1'b0, m_st[6:0]});
          free_at = cyc + 3 + 3 * H;
        end
      end
      while (sched.size() > 0 && sched[0].at == cyc) begin
        exp_val = sched[0].v;
        void'(sched.pop_front());
      end
    end
  end

  int frames = 0;
  bit prev_vld = 0;
  always @(posedge clk) begin
    #1;
    check("cycle_io_out", io_out, exp_val);
    if (io_out[7] && !prev_vld) frames++;
    prev_vld = io_out[7];
  end

  task automatic pulse(input bit c, input logic [3:0] p);
    @(negedge clk);
    cmd = c; payload = p; strb = 1'b1;
    @(posedge clk);
    #2 strb = 1'b0;
  endtask

  task automatic cfg(input bit corr, input logic [2:0] p);
    pulse(1'b1, {corr, p});
    @(posedge clk);
  endtask

  task automatic frame(input logic [3:0] nib, output logic [7:0] b_rx, b_fix, b_st);
    pulse(1'b0, nib);
    for (int e = 1; e <= 9; e++) begin
      @(posedge clk); #2;
      if (e == 3) b_rx = io_out;
      if (e == 5) b_fix = io_out;
      if (e == 7) b_st = io_out;
    end
  endtask

  task automatic frame_expect(input string name, input logic [3:0] nib,
                              input logic [7:0] x_rx, x_fix, x_st);
    pulse(1'b0, nib);
    for (int e = 1; e <= 9; e++) begin
      @(posedge clk); #2;
      if (e <= 2)      check({name, "_vld_low"}, {7'd0, io_out[7]}, 8'h00);
      else if (e <= 4) check({name, "_rx"}, io_out, x_rx);
      else if (e <= 6) check({name, "_fix"}, io_out, x_fix);
      else if (e <= 8) check({name, "_stat"}, io_out, x_st);
      else             check({name, "_idle"}, io_out, {1'b0, x_st[6:0]});
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want $finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] r, f, s;
    int f0;

    check("pin_encode_B", {1'b0, encode(4'hB)}, 8'h1B);
    check("pin_syn_pos6", {5'd0, syndrome(inj_mask(3'd6))}, 8'h06);
    check("pin_nearest", {1'b0, nearest(7'h1F)}, 8'h1B);

    #2 rst = 1'b1;
    #1 check("reset_io_out", io_out, 8'h00);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    frame_expect("clean_B", 4'hB, 8'h9B, 8'h9B, 8'h80);
    cfg(1'b1, 3'd6);
    frame_expect("corr_pos6", 4'hB, 8'h9F, 8'h9B, 8'hE1);
    cfg(1'b0, 3'd6);
    frame_expect("nocorr_pos6", 4'hB, 8'h9F, 8'h9F, 8'hE1);

    for (int p = 1; p <= 7; p++) begin
      cfg(1'b1, 3'(p));
      for (int n = 0; n < 16; n++) begin
        frame(4'(n), r, f, s);
        check("sweep_fix", f, {1'b1, encode(4'(n))});
        check("sweep_syn", {5'd0, s[6:4]}, {5'd0, syndrome(inj_mask(3'(p)))});
        if (n == 0) check("sweep_cnt_first", {4'd0, s[3:0]}, 8'h01);
      end
      check("sweep_cnt_sat", {4'd0, s[3:0]}, 8'h0F);
    end

    cfg(1'b1, 3'd1);
    f0 = frames;
    @(negedge clk);
    cmd = 1'b0; payload = 4'h5; strb = 1'b1;
    repeat (20) @(negedge clk);
    strb = 1'b0;
    repeat (5) @(posedge clk);
    #2 check("held_strobe_frames", 8'(frames - f0), 8'd1);

    f0 = frames;
    pulse(1'b0, 4'h6);
    repeat (4) @(posedge clk);
    @(negedge clk);
    cmd = 1'b0; payload = 4'h9; strb = 1'b1;
    @(posedge clk);
    #2 strb = 1'b0;
    repeat (6) @(posedge clk);
    #2 check("busy_pulse_frames", 8'(frames - f0), 8'd1);
    frame(4'h0, r, f, s);
    check("busy_pulse_cnt", {4'd0, s[3:0]}, 8'h03);

    cfg(1'b1, 3'd6);
    pulse(1'b0, 4'hB);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    #1 check("async_reset_brx", io_out, 8'h00);
    @(negedge clk);
    rst = 1'b0;
    frame_expect("after_reset", 4'hB, 8'h9B, 8'h9B, 8'h80);

    @(negedge clk);
    rst = 1'b1; cmd = 1'b0; payload = 4'hB; strb = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    f0 = frames;
    repeat (12) @(negedge clk);
    check("strb_high_at_release", 8'(frames - f0), 8'd0);
    strb = 1'b0;
    @(negedge clk);
    frame_expect("rearmed", 4'h0, 8'h80, 8'h80, 8'h80);

    repeat (2) @(posedge clk);
    #2;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
